// File: rtl/can_rx_destuffer.sv
// can_rx_destuffer: CAN receive bit destuffer with dynamic and FD fixed stuffing and stuff-count reporting.
module can_rx_destuffer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reset_mode_i,
    input  logic       sample_point_i,
    input  logic       rx_bit_i,
    input  logic       sof_i,
    input  logic       stuff_enable_i,
    input  logic       fixed_stuff_i,
    output logic       bit_valid_o,
    output logic       bit_o,
    output logic       stuff_bit_o,
    output logic       stuff_err_o,
    output logic [2:0] stuff_count_o,
    output logic [2:0] stuff_count_gray_o,
    output logic       stuff_parity_o
);
    typedef enum logic [1:0] {IDLE, DYN, FIXED, ERR} state_t;
    state_t     state_q, state_d;
    logic       prev_q, prev_d;
    logic [2:0] same_q, same_d;
    logic [2:0] fix_q, fix_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bv_q, bv_d;
    logic       bit_q, bit_d;
    logic       sb_q, sb_d;
    logic       se_q, se_d;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prev_q  <= 1'b1;
            same_q  <= 3'd0;
            fix_q   <= 3'd0;
            cnt_q   <= 3'd0;
            bv_q    <= 1'b0;
            bit_q   <= 1'b0;
            sb_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            same_q  <= same_d;
            fix_q   <= fix_d;
            cnt_q   <= cnt_d;
            bv_q    <= bv_d;
            bit_q   <= bit_d;
            sb_q    <= sb_d;
            se_q    <= se_d;
        end
    end
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        same_d  = same_q;
        fix_d   = fix_q;
        cnt_d   = cnt_q;
        bv_d    = 1'b0;
        bit_d   = bit_q;
        sb_d    = 1'b0;
        se_d    = 1'b0;
        if (reset_mode_i) begin
            state_d = IDLE;
            prev_d  = 1'b1;
            same_d  = 3'd0;
            fix_d   = 3'd0;
            cnt_d   = 3'd0;
        end else if (sample_point_i && sof_i) begin
            state_d = DYN;
            bv_d    = 1'b1;
            bit_d   = rx_bit_i;
            prev_d  = rx_bit_i;
            same_d  = 3'd1;
            fix_d   = 3'd0;
            cnt_d   = 3'd0;
        end else if (sample_point_i) begin
            case (state_q)
                DYN: begin
                    prev_d = rx_bit_i;
                    // Entry into the fixed-stuff region: this bit is the leading fixed stuff bit
                    if (stuff_enable_i && fixed_stuff_i) begin
                        fix_d   = 3'd0;
                        state_d = (rx_bit_i != prev_q) ? FIXED : ERR;
                        sb_d    = rx_bit_i != prev_q;
                        se_d    = rx_bit_i == prev_q;
                    end else if (stuff_enable_i && same_q == 3'd5) begin
                        sb_d    = rx_bit_i != prev_q;
                        se_d    = rx_bit_i == prev_q;
                        state_d = (rx_bit_i != prev_q) ? DYN : ERR;
                        cnt_d   = (rx_bit_i != prev_q) ? cnt_q + 3'd1 : cnt_q;
                        same_d  = 3'd1;
                    end else begin
                        bv_d   = 1'b1;
                        bit_d  = rx_bit_i;
                        same_d = (stuff_enable_i && rx_bit_i == prev_q) ? same_q + 3'd1 : 3'd1;
                    end
                end
                FIXED: begin
                    prev_d = rx_bit_i;
                    if (!stuff_enable_i || !fixed_stuff_i) begin
                        state_d = DYN;
                        bv_d    = 1'b1;
                        bit_d   = rx_bit_i;
                        same_d  = 3'd1;
                    end else if (fix_q == 3'd4) begin
                        fix_d   = 3'd0;
                        sb_d    = rx_bit_i != prev_q;
                        se_d    = rx_bit_i == prev_q;
                        state_d = (rx_bit_i != prev_q) ? FIXED : ERR;
                    end else begin
                        bv_d  = 1'b1;
                        bit_d = rx_bit_i;
                        fix_d = fix_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bit_valid_o        = bv_q;
    assign bit_o              = bit_q;
    assign stuff_bit_o        = sb_q;
    assign stuff_err_o        = se_q;
    assign stuff_count_o      = cnt_q;
    assign stuff_count_gray_o = {cnt_q[2], cnt_q[2] ^ cnt_q[1], cnt_q[1] ^ cnt_q[0]};
    assign stuff_parity_o     = ^stuff_count_gray_o;
endmodule

// File: tb/tb_can_rx_destuffer.sv
// tb_can_rx_destuffer: scoreboard bench for the CAN receive destuffer.
module tb_can_rx_destuffer;
    localparam logic [1:0] N = 2'd0, D = 2'd1, S = 2'd2, E = 2'd3;
    typedef struct packed {logic [1:0] k; logic b;} exp_t;
    logic clk_i = 1'b0, rst_i = 1'b1, reset_mode_i = 1'b0, sample_point_i = 1'b0;
    logic rx_bit_i = 1'b1, sof_i = 1'b0, stuff_enable_i = 1'b1, fixed_stuff_i = 1'b0;
    logic bit_valid_o, bit_o, stuff_bit_o, stuff_err_o, stuff_parity_o;
    logic [2:0] stuff_count_o, stuff_count_gray_o;
    exp_t sb_q[$];
    int nvec = 0, nerr = 0;
    can_rx_destuffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .reset_mode_i(reset_mode_i),
        .sample_point_i(sample_point_i), .rx_bit_i(rx_bit_i), .sof_i(sof_i),
        .stuff_enable_i(stuff_enable_i), .fixed_stuff_i(fixed_stuff_i),
        .bit_valid_o(bit_valid_o), .bit_o(bit_o), .stuff_bit_o(stuff_bit_o),
        .stuff_err_o(stuff_err_o), .stuff_count_o(stuff_count_o),
        .stuff_count_gray_o(stuff_count_gray_o), .stuff_parity_o(stuff_parity_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk_strobes(input string nm, input logic [1:0] k, input logic b);
        logic [2:0] want;
        want = {k == D, k == S, k == E};
        nvec++;
        if ({bit_valid_o, stuff_bit_o, stuff_err_o} !== want || (k == D && bit_o !== b)) begin
            nerr++;
            $display("FAIL %s: got bv/sb/se=%b%b%b bit=%b, want %b bit=%b",
                     nm, bit_valid_o, stuff_bit_o, stuff_err_o, bit_o, want, b);
        end
    endtask
    task automatic smp(input logic rx, input logic sof, input logic en, input logic fx,
                       input logic [1:0] k, input logic b);
        exp_t e;
        @(negedge clk_i);
        sample_point_i = 1'b1; rx_bit_i = rx; sof_i = sof; stuff_enable_i = en; fixed_stuff_i = fx;
        sb_q.push_back('{k: k, b: b});
        @(negedge clk_i);
        sample_point_i = 1'b0; sof_i = 1'b0;
        e = sb_q.pop_front();
        chk_strobes("sample", e.k, e.b);
        @(negedge clk_i);
        chk_strobes("one_cycle", N, 1'b0);
    endtask
    task automatic chk_count(input string nm, input logic [2:0] c);
        logic [2:0] g;
        g = c ^ (c >> 1);
        nvec++;
        if (stuff_count_o !== c || stuff_count_gray_o !== g || stuff_parity_o !== (g[0] ^ g[1] ^ g[2])) begin
            nerr++;
            $display("FAIL %s: got cnt=%0d gray=%b par=%b, want cnt=%0d gray=%b par=%b",
                     nm, stuff_count_o, stuff_count_gray_o, stuff_parity_o, c, g, g[0] ^ g[1] ^ g[2]);
        end
    endtask
    task automatic pulse_rm();
        @(negedge clk_i); reset_mode_i = 1'b1;
        @(negedge clk_i); reset_mode_i = 1'b0;
        chk_strobes("reset_mode", N, 1'b0);
    endtask
    task automatic test_reset();
        #12;
        chk_strobes("reset_strobes", N, 1'b0);
        chk_count("reset_count", 3'd0);
        @(negedge clk_i); rst_i = 1'b0;
        smp(1'b0, 1'b0, 1'b1, 1'b0, N, 1'b0);
    endtask
    task automatic test_dyn_stuff();
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        smp(1'b1, 1'b0, 1'b1, 1'b0, S, 1'b0);
        smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        chk_count("dyn_stuff_count", 3'd1);
    endtask
    task automatic test_stuff_err();
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        smp(1'b0, 1'b0, 1'b1, 1'b0, E, 1'b0);
        for (int i = 0; i < 3; i++) smp(1'($urandom_range(1)), 1'b0, 1'b1, 1'b0, N, 1'b0);
        chk_count("err_count_held", 3'd0);
    endtask
    task automatic test_wrap();
        logic lvl = 1'b0;
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 4; i++) smp(lvl, 1'b0, 1'b1, 1'b0, D, lvl);
            smp(~lvl, 1'b0, 1'b1, 1'b0, S, 1'b0);
            lvl = ~lvl;
            if (k == 4) chk_count("count_mid", 3'd5);
        end
        chk_count("count_wrap", 3'd1);
    endtask
    task automatic test_fixed();
        logic [3:0] dat = 4'b1101;
        smp(1'b1, 1'b1, 1'b1, 1'b0, D, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b1, S, 1'b0);
        for (int i = 3; i >= 0; i--) smp(dat[i], 1'b0, 1'b1, 1'b1, D, dat[i]);
        smp(1'b0, 1'b0, 1'b1, 1'b1, S, 1'b0);
        smp(1'b1, 1'b0, 1'b1, 1'b0, D, 1'b1);
        chk_count("fixed_not_counted", 3'd0);
        smp(1'b1, 1'b1, 1'b1, 1'b0, D, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b1, S, 1'b0);
        for (int i = 3; i >= 0; i--) smp(dat[i], 1'b0, 1'b1, 1'b1, D, dat[i]);
        smp(1'b1, 1'b0, 1'b1, 1'b1, E, 1'b0);
        smp(1'b0, 1'b0, 1'b1, 1'b1, N, 1'b0);
    endtask
    task automatic test_reset_mode();
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        smp(1'b1, 1'b0, 1'b1, 1'b0, S, 1'b0);
        for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 1'b1, 1'b0, D, 1'b1);
        chk_count("pre_reset_mode", 3'd1);
        pulse_rm();
        chk_count("reset_mode_count", 3'd0);
        for (int i = 0; i < 5; i++) smp(1'b1, 1'b0, 1'b1, 1'b0, N, 1'b0);
    endtask
    task automatic test_sof_vs_reset_mode();
        @(negedge clk_i);
        reset_mode_i = 1'b1; sample_point_i = 1'b1; sof_i = 1'b1; rx_bit_i = 1'b0;
        @(negedge clk_i);
        reset_mode_i = 1'b0; sample_point_i = 1'b0; sof_i = 1'b0;
        chk_strobes("sof_vs_reset_mode", N, 1'b0);
        smp(1'b0, 1'b0, 1'b1, 1'b0, N, 1'b0);
    endtask
    task automatic test_back_to_back();
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        for (int i = 0; i < 4; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, D, 1'b0);
        smp(1'b0, 1'b0, 1'b1, 1'b0, E, 1'b0);
        smp(1'b1, 1'b1, 1'b0, 1'b0, D, 1'b1);
        for (int i = 0; i < 6; i++) smp(1'b1, 1'b0, 1'b0, 1'b0, D, 1'b1);
        for (int i = 0; i < 4; i++) smp(1'b1, 1'b0, 1'b1, 1'b0, D, 1'b1);
        smp(1'b0, 1'b0, 1'b1, 1'b0, S, 1'b0);
        chk_count("b2b_count", 3'd1);
    endtask
    task automatic test_async_reset();
        smp(1'b0, 1'b1, 1'b1, 1'b0, D, 1'b0);
        @(negedge clk_i);
        sample_point_i = 1'b1; rx_bit_i = 1'b1;
        @(posedge clk_i); #1;
        sample_point_i = 1'b0;
        rst_i = 1'b1; #1;
        chk_strobes("async_reset", N, 1'b0);
        @(negedge clk_i); rst_i = 1'b0;
        chk_strobes("after_reset", N, 1'b0);
        for (int i = 0; i < 3; i++) smp(1'b0, 1'b0, 1'b1, 1'b0, N, 1'b0);
    endtask
    initial begin
        test_reset();
        test_dyn_stuff();
        test_stuff_err();
        test_wrap();
        test_fixed();
        test_reset_mode();
        test_sof_vs_reset_mode();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/can_rx_destuffer.md
CAN_RX_DESTUFFER -- requirements
Module: can_rx_destuffer

Interface
REQ-001 Parameter: none; the block SHALL be fixed-function.
REQ-002 clk_i  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 reset_mode_i  input  1  controller reset mode; synchronous clear, priority over all other inputs except rst_i.
REQ-005 sample_point_i  input  1  one-cycle strobe marking a valid sampled bus bit.
REQ-006 rx_bit_i  input  1  sampled bus level; qualified by sample_point_i.
REQ-007 sof_i  input  1  asserted with the sample_point_i of the SOF bit; starts a frame.
REQ-008 stuff_enable_i  input  1  1 = stuff checking active (SOF through CRC field); 0 = bits pass unchecked.
REQ-009 fixed_stuff_i  input  1  1 = FD CRC field fixed stuffing; 0 = dynamic stuffing.
REQ-010 bit_valid_o  output  1  one-cycle strobe: destuffed data bit on bit_o.
REQ-011 bit_o  output  1  destuffed data bit value.
REQ-012 stuff_bit_o  output  1  one-cycle strobe: a correct stuff bit was removed.
REQ-013 stuff_err_o  output  1  one-cycle strobe: stuff rule violated.
REQ-014 stuff_count_o  output  3  dynamic stuff bits removed this frame, modulo 8.
REQ-015 stuff_count_gray_o  output  3  Gray code of stuff_count_o (b2, b2^b1, b1^b0).
REQ-016 stuff_parity_o  output  1  even parity over stuff_count_gray_o (XOR of its three bits).

Function
REQ-017 The block SHALL hold states IDLE, DYN, FIXED, ERR, plus registers prev_bit (1 b), same_cnt (3 b), fix_cnt (3 b), stuff_count (3 b).
REQ-018 All strobe outputs SHALL be registered and appear exactly 1 clk after the causing sample_point_i; at most one of bit_valid_o, stuff_bit_o, stuff_err_o SHALL be high in any cycle.
REQ-019 Input priority SHALL be: reset_mode_i > sof_i > normal processing; inputs are only evaluated on sample_point_i, except reset_mode_i (every cycle).
REQ-020 IDLE: sample bits ignored; sof_i with sample_point_i -> DYN, bit_valid_o=1, bit_o=rx_bit_i, prev_bit=rx_bit_i, same_cnt=1, stuff_count=0, fix_cnt=0.
REQ-021 DYN, stuff_enable_i=0: every sample bit emitted as data; same_cnt=1, prev_bit updated; no errors.
REQ-022 DYN, stuff_enable_i=1, same_cnt<5: bit emitted as data; if rx_bit_i==prev_bit same_cnt+=1 else same_cnt=1; prev_bit=rx_bit_i.
REQ-023 DYN, same_cnt==5: bit is a stuff bit; if rx_bit_i!=prev_bit -> stuff_bit_o=1, not emitted, stuff_count+=1 (wraps 7->0), same_cnt=1, prev_bit=rx_bit_i; else stuff_err_o=1, -> ERR.
REQ-024 DYN with fixed_stuff_i=1 at a sample point -> FIXED; that same bit SHALL be treated as the leading fixed stuff bit (rules of REQ-026), fix_cnt=0.
REQ-025 FIXED: data bits emitted, fix_cnt+=1 per data bit; when fix_cnt==4 the next bit is a fixed stuff bit and fix_cnt=0.
REQ-026 Fixed stuff bit: rx_bit_i SHALL equal ~prev_bit -> stuff_bit_o=1, not counted in stuff_count; else stuff_err_o=1, -> ERR. prev_bit updated for all bits; same_cnt not used.
REQ-027 FIXED with fixed_stuff_i=0 or stuff_enable_i=0 at a sample point -> DYN with stuff_enable rules of REQ-021; bit processed as data.
REQ-028 ERR: no strobes; stuff_count held; exit only by sof_i (as REQ-020) or reset_mode_i.
REQ-029 sof_i in DYN/FIXED/ERR SHALL restart the frame exactly as REQ-020, discarding prior counts.
REQ-030 reset_mode_i=1: next clk state=IDLE, all counters 0, prev_bit=1, strobes 0; held while asserted.
REQ-031 stuff_count_o/gray/parity SHALL be registered-state derived, stable between updates, valid from the cycle after update.

Reset
REQ-032 rst_i SHALL asynchronously force IDLE, prev_bit=1, same_cnt=0, fix_cnt=0, stuff_count=0, all outputs 0 (stuff_count_gray_o=000, stuff_parity_o=0).
REQ-033 Reset mid-frame SHALL abort without any trailing strobe; first activity after release requires sof_i.

Verification
REQ-034 SOF=0 then bits 0,0,0,0,1(stuff),0 with stuff_enable_i=1 -> 5 bit_valid (0,0,0,0,0 counting SOF), stuff_bit_o once, then bit_valid bit_o=0; stuff_count_o=1, gray=001, parity=1.
REQ-035 SOF=0 then 0,0,0,0,0 (6th zero) -> stuff_err_o one pulse 1 clk after 6th sample, no further strobes until next sof_i.
REQ-036 Nine dynamic stuff bits in one frame -> stuff_count_o=1 (wrap), gray=001, parity=1.
REQ-037 fixed_stuff_i=1 with prev_bit=1: bits 0(stuff),1,0,1,1,0(stuff) -> stuff_bit_o at bits 1 and 6, four bit_valid between; replacing bit 6 with 1 -> stuff_err_o.
REQ-038 reset_mode_i pulsed mid-frame with same_cnt=4 -> IDLE, stuff_count_o=0; subsequent 5 equal bits without sof_i produce no strobes.
REQ-039 sof_i coincident with reset_mode_i -> reset_mode_i wins, state IDLE, no bit_valid_o.
